tile_grid_drawer: RTL and testbench

//  Parametrised successor tile-number renderer for the sliding-puzzle display path.
//  - On a start pulse, snapshots the packed board state.
//  - Streams one pixel write per cycle (plot/x/y/color) to the VGA adapter for every glyph cell of every tile.
//  - Blank cells are actively erased in BG colour, so stale glyphs never survive a move.
//  - Sits between the game-state datapath and the VGA adapter; start/busy/done replaces free-running redraw.

---
 rtl/tile_grid_drawer_pkg.sv | 42 ++++
 rtl/tile_grid_drawer_if.sv | 28 ++
 rtl/tile_grid_drawer_glyph_rom.sv | 63 ++++++
 rtl/tile_grid_drawer.sv | 188 ++++++++++++++++++
 tb/tb_tile_grid_drawer.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/tile_grid_drawer_pkg.sv
// Shared types and constants for the tile grid drawer.
//   state_e        : drawer FSM state encoding
//   FG/BG_COLOR_DEF: default glyph-set / glyph-clear colours
//   seg_mask()     : 7-segment glyph bitmap (abcdefg, a = bit 6) for values 1..15 (hex digits)
package tile_grid_drawer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAW  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [2:0] FG_COLOR_DEF = 3'b111;
    localparam logic [2:0] BG_COLOR_DEF = 3'b000;

    // Value 0 is the empty tile and has no segments lit.
    function automatic logic [6:0] seg_mask(input logic [3:0] value);
        logic [6:0] m;
        m = 7'h00;
        case (value)
            4'h1: m = 7'h30;
            4'h2: m = 7'h6D;
            4'h3: m = 7'h79;
            4'h4: m = 7'h33;
            4'h5: m = 7'h5B;
            4'h6: m = 7'h5F;
            4'h7: m = 7'h70;
            4'h8: m = 7'h7F;
            4'h9: m = 7'h7B;
            4'hA: m = 7'h77;
            4'hB: m = 7'h1F;
            4'hC: m = 7'h4E;
            4'hD: m = 7'h3D;
            4'hE: m = 7'h4F;
            4'hF: m = 7'h47;
            default: m = 7'h00;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/tile_grid_drawer_if.sv
// Control handshake and pixel-write bus between host, drawer and VGA adapter.
//   start            : begin a frame (host -> drawer)
//   busy, done       : frame status (drawer -> host)
//   plot, x_out, y_out, color_out : pixel write (drawer -> VGA adapter)
// master = drawer side, slave = host / adapter side.
interface tile_grid_drawer_if #(
    parameter int unsigned X_W     = 8,
    parameter int unsigned Y_W     = 7,
    parameter int unsigned COLOR_W = 3
) ();
    logic               start;
    logic               busy;
    logic               done;
    logic               plot;
    logic [X_W-1:0]     x_out;
    logic [Y_W-1:0]     y_out;
    logic [COLOR_W-1:0] color_out;

    modport master (
        input  start,
        output busy, done, plot, x_out, y_out, color_out
    );

    modport slave (
        output start,
        input  busy, done, plot, x_out, y_out, color_out
    );
endinterface

// File: rtl/tile_grid_drawer_glyph_rom.sv
// Glyph ROM: synchronous read, one cycle latency.
//   clk, resetn : clock, synchronous active-low reset
//   value       : tile value (0 and values above 15 read as blank)
//   gx, gy      : pixel position inside the glyph cell
//   pix         : registered glyph bit
// Glyphs are seven-segment hex digits, 2 px strokes with a 1 px margin, laid out
// relative to GLYPH_W x GLYPH_H.
module tile_grid_drawer_glyph_rom
    import tile_grid_drawer_pkg::*;
#(
    parameter int unsigned NUM_W   = 4,
    parameter int unsigned GLYPH_W = 10,
    parameter int unsigned GLYPH_H = 20,
    parameter int unsigned GX_W    = 4,
    parameter int unsigned GY_W    = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [NUM_W-1:0] value,
    input  logic [GX_W-1:0]  gx,
    input  logic [GY_W-1:0]  gy,
    output logic             pix
);
    localparam int unsigned RX = GLYPH_W - 3;      // right stroke first column
    localparam int unsigned MY = GLYPH_H / 2 - 1;  // middle stroke first row
    localparam int unsigned BY = GLYPH_H - 3;      // bottom stroke first row

    logic       in_range;
    logic [6:0] m;
    logic       col_l, col_r, in_h, row_t, row_m, row_b, up, lo, bit_d;

    if (NUM_W > 4) begin : g_wide
        assign in_range = (value[NUM_W-1:4] == '0);
    end else begin : g_narrow
        assign in_range = 1'b1;
    end

    // Segment geometry decode
    always_comb begin
        m     = seg_mask(4'(value));
        col_l = (gx == GX_W'(1)) || (gx == GX_W'(2));
        col_r = (gx == GX_W'(RX)) || (gx == GX_W'(RX + 1));
        in_h  = (gx >= GX_W'(1)) && (gx <= GX_W'(RX + 1));
        row_t = (gy == GY_W'(1)) || (gy == GY_W'(2));
        row_m = (gy == GY_W'(MY)) || (gy == GY_W'(MY + 1));
        row_b = (gy == GY_W'(BY)) || (gy == GY_W'(BY + 1));
        up    = (gy >= GY_W'(1)) && (gy <= GY_W'(MY + 1));
        lo    = (gy >= GY_W'(MY)) && (gy <= GY_W'(BY + 1));
        bit_d = in_range && ((m[6] && row_t && in_h) ||
                             (m[5] && col_r && up)   ||
                             (m[4] && col_r && lo)   ||
                             (m[3] && row_b && in_h) ||
                             (m[2] && col_l && lo)   ||
                             (m[1] && col_l && up)   ||
                             (m[0] && row_m && in_h));
    end

    // Read register
    always_ff @(posedge clk) begin
        if (!resetn) pix <= 1'b0;
        else         pix <= bit_d;
    end
endmodule

// File: rtl/tile_grid_drawer.sv
// Tile-number renderer: on start, snapshots the board and streams one pixel
// write per cycle for every glyph cell of every tile, erasing blanks in BG.
//   clk, resetn : clock, synchronous active-low reset
//   cursor      : tile index to draw inverted (only with TILE_DRAWER_HIGHLIGHT_EN)
//   tiles       : packed board, tile t at [t*NUM_W +: NUM_W], t = row*GRID+col
//   bus         : start/busy/done handshake and plot/x_out/y_out/color_out pixel bus
// Build option: define TILE_DRAWER_HIGHLIGHT_EN to add the cursor port.
module tile_grid_drawer
    import tile_grid_drawer_pkg::*;
#(
    parameter int unsigned GRID       = 4,
    parameter int unsigned NUM_W      = 4,
    parameter int unsigned TILE_PITCH = 29,
    parameter int unsigned X0         = 0,
    parameter int unsigned Y0         = 0,
    parameter int unsigned GLYPH_W    = 10,
    parameter int unsigned GLYPH_H    = 20,
    parameter int unsigned X_W        = 8,
    parameter int unsigned Y_W        = 7,
    parameter int unsigned COLOR_W    = 3,
    parameter logic [COLOR_W-1:0] FG_COLOR = COLOR_W'(FG_COLOR_DEF),
    parameter logic [COLOR_W-1:0] BG_COLOR = COLOR_W'(BG_COLOR_DEF)
) (
    input  logic                       clk,
    input  logic                       resetn,
`ifdef TILE_DRAWER_HIGHLIGHT_EN
    input  logic [NUM_W-1:0]           cursor,
`endif
    input  logic [GRID*GRID*NUM_W-1:0] tiles,
    tile_grid_drawer_if.master         bus
);
    localparam int unsigned NUM_TILES = GRID * GRID;
    localparam int unsigned TILE_W    = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
    localparam int unsigned COL_W     = (GRID > 1) ? $clog2(GRID) : 1;
    localparam int unsigned GX_W      = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
    localparam int unsigned GY_W      = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;

    state_e                     state, next_state;
    logic [GRID*GRID*NUM_W-1:0] tiles_q;
    logic [TILE_W-1:0]          tile;
    logic [COL_W-1:0]           col;
    logic [GX_W-1:0]            gx;
    logic [GY_W-1:0]            gy;
    logic [X_W-1:0]             x_base;
    logic [Y_W-1:0]             y_base;
    logic                       last_px, last_tile, hl_hit;
    logic [NUM_W-1:0]           tile_val, val_eff;
    logic                       busy_d, done_d, plot_d, inv_d, inv_q, rom_pix;
    logic [X_W-1:0]             x_d;
    logic [Y_W-1:0]             y_d;

    assign last_px   = (gx == GX_W'(GLYPH_W - 1)) && (gy == GY_W'(GLYPH_H - 1));
    assign last_tile = (tile == TILE_W'(NUM_TILES - 1));
    assign tile_val  = tiles_q[32'(tile) * NUM_W +: NUM_W];

    // Values that cannot appear on this board size are erased like the empty tile
    if ((1 << NUM_W) > NUM_TILES) begin : g_clip
        assign val_eff = (tile_val < NUM_W'(NUM_TILES)) ? tile_val : '0;
    end else begin : g_noclip
        assign val_eff = tile_val;
    end

`ifdef TILE_DRAWER_HIGHLIGHT_EN
    logic [NUM_W-1:0] cursor_q;
    // tile never exceeds NUM_TILES-1, so an out-of-range cursor never matches
    assign hl_hit = (32'(tile) == 32'(cursor_q));
    always_ff @(posedge clk) begin
        if (!resetn)                             cursor_q <= '0;
        else if (state == ST_IDLE && bus.start)  cursor_q <= cursor;
    end
`else
    assign hl_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (bus.start) next_state = ST_DRAW;
            ST_DRAW:  if (last_px && last_tile) next_state = ST_FLUSH;
            ST_FLUSH: next_state = ST_DONE;
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Output logic: values for the output registers, one cycle ahead
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        plot_d = 1'b0;
        inv_d  = 1'b0;
        x_d    = '0;
        y_d    = '0;
        busy_d = (next_state != ST_IDLE);
        done_d = (next_state == ST_DONE);
        if (state == ST_DRAW) begin
            plot_d = 1'b1;
            inv_d  = hl_hit;
            x_d    = x_base + X_W'(gx);
            y_d    = y_base + Y_W'(gy);
        end
    end

    // Snapshot and scan counters; x_base/y_base track the tile origin by accumulation
    always_ff @(posedge clk) begin
        if (!resetn) begin
            tiles_q <= '0;
            tile    <= '0;
            col     <= '0;
            gx      <= '0;
            gy      <= '0;
            x_base  <= '0;
            y_base  <= '0;
        end else if (state == ST_IDLE && bus.start) begin
            tiles_q <= tiles;
            tile    <= '0;
            col     <= '0;
            gx      <= '0;
            gy      <= '0;
            x_base  <= X_W'(X0);
            y_base  <= Y_W'(Y0);
        end else if (state == ST_DRAW) begin
            if (gx == GX_W'(GLYPH_W - 1)) begin
                gx <= '0;
                if (gy == GY_W'(GLYPH_H - 1)) begin
                    gy   <= '0;
                    tile <= tile + TILE_W'(1);
                    if (col == COL_W'(GRID - 1)) begin
                        col    <= '0;
                        x_base <= X_W'(X0);
                        y_base <= y_base + Y_W'(TILE_PITCH);
                    end else begin
                        col    <= col + COL_W'(1);
                        x_base <= x_base + X_W'(TILE_PITCH);
                    end
                end else begin
                    gy <= gy + GY_W'(1);
                end
            end else begin
                gx <= gx + GX_W'(1);
            end
        end
    end

    tile_grid_drawer_glyph_rom #(
        .NUM_W   (NUM_W),
        .GLYPH_W (GLYPH_W),
        .GLYPH_H (GLYPH_H),
        .GX_W    (GX_W),
        .GY_W    (GY_W)
    ) u_rom (
        .clk    (clk),
        .resetn (resetn),
        .value  (val_eff),
        .gx     (gx),
        .gy     (gy),
        .pix    (rom_pix)
    );

    // Output registers, aligned with the ROM read register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
            bus.plot  <= 1'b0;
            bus.x_out <= '0;
            bus.y_out <= '0;
            inv_q     <= 1'b0;
        end else begin
            bus.busy  <= busy_d;
            bus.done  <= done_d;
            bus.plot  <= plot_d;
            bus.x_out <= x_d;
            bus.y_out <= y_d;
            inv_q     <= inv_d;
        end
    end

    // Colour is a mux of registered ROM bit and highlight flag; zero when idle
    assign bus.color_out = !bus.plot ? '0 : ((rom_pix ^ inv_q) ? FG_COLOR : BG_COLOR);
endmodule

// File: tb/tb_tile_grid_drawer.sv
// Directed bench for tile_grid_drawer: default 4x4 instance and a 3x3, pitch-40 instance.
// Pixel records are packed {x[17:10], y[9:3], color[2:0]}.
module tb_tile_grid_drawer;
    logic        clk;
    logic        resetn;
    logic [63:0] tiles4;
    logic [35:0] tiles3;
    logic [3:0]  cursor4;
    logic [3:0]  cursor3;

    int n_checks;
    int n_pass;

    logic [17:0] pix     [3200];
    logic [17:0] ref_pix [3200];
    int          n_plots, first_k, done_k, busy_bad;

    tile_grid_drawer_if #(.X_W(8), .Y_W(7), .COLOR_W(3)) bus4 ();
    tile_grid_drawer_if #(.X_W(8), .Y_W(7), .COLOR_W(3)) bus3 ();

    tile_grid_drawer dut4 (
        .clk    (clk),
        .resetn (resetn),
`ifdef TILE_DRAWER_HIGHLIGHT_EN
        .cursor (cursor4),
`endif
        .tiles  (tiles4),
        .bus    (bus4)
    );

    tile_grid_drawer #(.GRID(3), .TILE_PITCH(40)) dut3 (
        .clk    (clk),
        .resetn (resetn),
`ifdef TILE_DRAWER_HIGHLIGHT_EN
        .cursor (cursor3),
`endif
        .tiles  (tiles3),
        .bus    (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int fg_count(input int first, input int n);
        int c;
        c = 0;
        for (int i = first; i < first + n; i++)
            if (pix[i][2:0] == 3'b111) c++;
        return c;
    endfunction

    // Starting at the negedge after start was sampled (k=1), record plots until done or budget.
    task automatic capture(input bit g3, input int poke_k, input int max_k);
        logic        p, b, d;
        logic [17:0] rec;
        n_plots  = 0;
        first_k  = -1;
        done_k   = -1;
        busy_bad = 0;
        for (int k = 1; k <= max_k; k++) begin
            p   = g3 ? bus3.plot : bus4.plot;
            b   = g3 ? bus3.busy : bus4.busy;
            d   = g3 ? bus3.done : bus4.done;
            rec = g3 ? {bus3.x_out, bus3.y_out, bus3.color_out}
                     : {bus4.x_out, bus4.y_out, bus4.color_out};
            if (p) begin
                if (first_k < 0) first_k = k;
                if (n_plots < 3200) pix[n_plots] = rec;
                n_plots++;
                if (!b) busy_bad++;
            end
            if (d) begin
                done_k = k;
                break;
            end
            if (k == poke_k) begin
                bus4.start = 1'b1;
                tiles4     = {16{4'h8}};
            end else if (k == poke_k + 1) begin
                bus4.start = 1'b0;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic pulse_start4();
        @(negedge clk) bus4.start = 1'b1;
        @(negedge clk) bus4.start = 1'b0;
    endtask

    task automatic set_default_tiles();
        for (int t = 0; t < 16; t++) tiles4[t*4 +: 4] = (t == 15) ? 4'd0 : 4'(t + 1);
    endtask

    initial begin
        int mism, cnt;
        logic [17:0] e;
        n_checks = 0;
        n_pass   = 0;
        resetn   = 1'b0;
        bus4.start = 1'b1;
        bus3.start = 1'b1;
        set_default_tiles();
        tiles3  = '0;
        cursor4 = 4'd15;
        cursor3 = 4'd12;

        // Reset with start held high
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_plot",  int'(bus4.plot), 0);
        check("rst_busy",  int'(bus4.busy), 0);
        check("rst_done",  int'(bus4.done), 0);
        check("rst_xyc",   int'({bus4.x_out, bus4.y_out, bus4.color_out}), 0);
        bus4.start = 1'b0;
        bus3.start = 1'b0;
        resetn = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus4.plot || bus4.busy) cnt++;
        end
        check("idle_no_plot", cnt, 0);

        // Full default frame
        pulse_start4();
        capture(1'b0, -1, 4000);
        check("t2_plots",   n_plots, 3200);
        check("t2_first_k", first_k, 2);
        check("t2_done_k",  done_k, 3202);
        check("t2_busy",    busy_bad, 0);
        check("t2_busy_end", int'(bus4.busy), 0);
        check("t2_pix0",    int'(pix[0]), int'({8'd0, 7'd0, 3'd0}));
        check("t2_pix17",   int'(pix[17]), int'({8'd7, 7'd1, 3'd7}));
        check("t2_tile5_x", int'(pix[1000][17:10]), 29);
        check("t2_tile5_y", int'(pix[1000][9:3]), 29);
        check("t2_last_xy", int'(pix[3199][17:3]), int'({8'd96, 7'd106}));
        check("t2_fg_t0",   fg_count(0, 200), 36);
        check("t2_fg_t7",   fg_count(1400, 200), 96);
`ifdef TILE_DRAWER_HIGHLIGHT_EN
        check("t2_fg_t15",  fg_count(3000, 200), 200);
`else
        check("t2_fg_t15",  fg_count(3000, 200), 0);
`endif
        for (int i = 0; i < 3200; i++) ref_pix[i] = pix[i];

        // start and tiles poked mid-frame
        pulse_start4();
        capture(1'b0, 500, 4000);
        mism = 0;
        for (int i = 0; i < 3200; i++) if (pix[i] !== ref_pix[i]) mism++;
        check("t3_plots",  n_plots, 3200);
        check("t3_done_k", done_k, 3202);
        check("t3_stream", mism, 0);
        check("t3_fg_t0",  fg_count(0, 200), 36);
        set_default_tiles();

        // Reset at the 1000th plot
        pulse_start4();
        cnt = 0;
        for (int k = 0; k < 2000 && cnt < 1000; k++) begin
            if (bus4.plot) cnt++;
            if (cnt < 1000) @(negedge clk);
        end
        check("t4_reached", cnt, 1000);
        resetn = 1'b0;
        @(negedge clk);
        check("t4_plot", int'(bus4.plot), 0);
        check("t4_busy", int'(bus4.busy), 0);
        @(negedge clk) resetn = 1'b1;
        repeat (3) @(negedge clk);
        pulse_start4();
        capture(1'b0, -1, 4000);
        mism = 0;
        for (int i = 0; i < 3200; i++) if (pix[i] !== ref_pix[i]) mism++;
        check("t4_plots",   n_plots, 3200);
        check("t4_first_k", first_k, 2);
        check("t4_stream",  mism, 0);

        // 3x3 board, pitch 40, tile 7 holds out-of-range value 12
        for (int t = 0; t < 7; t++) tiles3[t*4 +: 4] = 4'(t + 1);
        tiles3[28 +: 4] = 4'd12;
        tiles3[32 +: 4] = 4'd8;
        @(negedge clk) bus3.start = 1'b1;
        @(negedge clk) bus3.start = 1'b0;
        capture(1'b1, -1, 4000);
        check("t5_plots",   n_plots, 1800);
        check("t5_done_k",  done_k, 1802);
        check("t5_fg_t0",   fg_count(0, 200), 36);
        check("t5_fg_t7",   fg_count(1400, 200), 0);
        check("t5_fg_t8",   fg_count(1600, 200), 96);
        check("t5_t4_xy",   int'(pix[800][17:3]), int'({8'd40, 7'd40}));
        check("t5_t8_xy",   int'(pix[1600][17:3]), int'({8'd80, 7'd80}));

`ifdef TILE_DRAWER_HIGHLIGHT_EN
        // Highlight tile 5; reference frame highlighted tile 15
        cursor4 = 4'd5;
        pulse_start4();
        capture(1'b0, -1, 4000);
        mism = 0;
        for (int i = 0; i < 3200; i++) begin
            e = ref_pix[i];
            if ((i >= 1000 && i < 1200) || i >= 3000) e[2:0] = ~e[2:0];
            if (pix[i] !== e) mism++;
        end
        check("t6_plots",  n_plots, 3200);
        check("t6_stream", mism, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
